aes_mixcol_arb: RTL and testbench

AES_MIXCOL_ARB -- requirements
Module: aes_mixcol_arb

---
 rtl/aes_mixcol_arb.sv | 140 ++++++++++++++
 tb/tb_aes_mixcol_arb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mixcol_arb.sv
`default_nettype none
// ============================================================================
// Module   : aes_mixcol_arb
// Purpose  : Round-robin arbiter sharing one forward and one inverse AES
//            MixColumns unit between an encrypt and a decrypt requester.
//            One operation in flight; IDLE -> ISSUE -> WAIT -> RESP.
// Revision : 1.0 - initial release
// ============================================================================
module aes_mixcol_arb #(
  parameter int MIX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  // forward (encrypt) requester
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [127:0] rsp0_data,
  // inverse (decrypt) requester
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp1_data,
  // shared column-mix units
  output logic [127:0] mix_in,
  output logic         fwd_en,
  output logic         inv_en,
  input  logic [127:0] fwd_out,
  input  logic [127:0] inv_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Last WAIT count value before the unit output is valid.
  localparam logic [2:0] c_LAT_LAST = 3'(MIX_LAT - 1);

  state_t       r_state;
  logic [2:0]   r_cnt;
  logic [127:0] r_mix_in;
  logic [127:0] r_result;
  logic         r_last;      // channel granted most recently
  logic         r_chan;      // channel of the operation in flight
  logic         r_fwd_en;
  logic         r_inv_en;
  logic         r_rsp0_valid;
  logic         r_rsp1_valid;

  logic w_idle;
  logic w_gnt;
  logic w_rdy0;
  logic w_rdy1;
  logic w_acc;
  logic w_rsp_hs;

  // Grant: a lone requester wins; on a tie the one not granted last wins.
  assign w_idle   = (r_state == S_IDLE);
  assign w_gnt    = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_rdy0   = w_idle && req0_valid && !w_gnt;
  assign w_rdy1   = w_idle && req1_valid &&  w_gnt;
  assign w_acc    = w_rdy0 || w_rdy1;
  assign w_rsp_hs = (r_rsp0_valid && rsp0_ready) || (r_rsp1_valid && rsp1_ready);

  // Readys are gated by rst_n so every output reads 0 while reset is held.
  assign req0_ready = w_rdy0 && rst_n;
  assign req1_ready = w_rdy1 && rst_n;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_data  = r_rsp0_valid ? r_result : 128'd0;
  assign rsp1_data  = r_rsp1_valid ? r_result : 128'd0;
  assign mix_in     = r_mix_in;
  assign fwd_en     = r_fwd_en;
  assign inv_en     = r_inv_en;
  assign busy       = (r_state != S_IDLE);

  // Operation sequencer: accept, pulse the unit enable, wait out the unit
  // latency, capture the result and hold it until the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_mix_in     <= 128'd0;
      r_result     <= 128'd0;
      r_last       <= 1'b1;
      r_chan       <= 1'b0;
      r_fwd_en     <= 1'b0;
      r_inv_en     <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      r_fwd_en <= 1'b0;
      r_inv_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_mix_in <= w_gnt ? req1_data : req0_data;
            r_chan   <= w_gnt;
            r_last   <= w_gnt;
            r_fwd_en <= !w_gnt;
            r_inv_en <= w_gnt;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= 3'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == c_LAT_LAST) begin
            r_result     <= r_chan ? inv_out : fwd_out;
            r_rsp0_valid <= !r_chan;
            r_rsp1_valid <= r_chan;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_mixcol_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_mixcol_arb
// Purpose  : Bench for aes_mixcol_arb with MIX_LAT=1 (instance 0) and
//            MIX_LAT=3 (instance 1), each with behavioural column-mix units.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_mixcol_arb;

  logic         clk;
  logic         rst_n      [2];
  logic         req0_valid [2];
  logic         req0_ready [2];
  logic [127:0] req0_data  [2];
  logic         rsp0_valid [2];
  logic         rsp0_ready [2];
  logic [127:0] rsp0_data  [2];
  logic         req1_valid [2];
  logic         req1_ready [2];
  logic [127:0] req1_data  [2];
  logic         rsp1_valid [2];
  logic         rsp1_ready [2];
  logic [127:0] rsp1_data  [2];
  logic [127:0] mix_in     [2];
  logic         fwd_en     [2];
  logic         inv_en     [2];
  logic [127:0] fwd_out    [2];
  logic [127:0] inv_out    [2];
  logic         busy       [2];

  int n_total = 0;
  int n_bad   = 0;

  // Transaction-level reference state per instance.
  bit           m_idle [2];
  int           m_t    [2];  // cycles since accept (accept cycle = 0)
  bit           m_ch   [2];
  bit           m_last [2];
  logic [127:0] m_mix  [2];

  int           acc_q [$];
  logic [127:0] obs_rsp0;
  logic [127:0] obs_rsp1;

  // ---------------------------------------------------------------- AES math
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] mixcol(input logic [127:0] s, input bit inv);
    logic [3:0]   base [4];
    logic [7:0]   a    [4];
    logic [7:0]   o;
    logic [127:0] r = '0;
    if (inv) begin base[0] = 4'd14; base[1] = 4'd11; base[2] = 4'd13; base[3] = 4'd9; end
    else     begin base[0] = 4'd2;  base[1] = 4'd3;  base[2] = 4'd1;  base[3] = 4'd1; end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 8*(4*c + j) -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o = o ^ gm(a[j], base[(j - rr + 4) % 4]);
        r[127 - 8*(4*c + rr) -: 8] = o;
      end
    end
    return r;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ------------------------------------------------------ DUTs + unit models
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic         fv [4];
    logic         iv [4];
    logic [127:0] fd [4];
    logic [127:0] id [4];
    logic [127:0] junk;

    aes_mixcol_arb #(.MIX_LAT(L)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .req0_valid (req0_valid[g]),
      .req0_ready (req0_ready[g]),
      .req0_data  (req0_data[g]),
      .rsp0_valid (rsp0_valid[g]),
      .rsp0_ready (rsp0_ready[g]),
      .rsp0_data  (rsp0_data[g]),
      .req1_valid (req1_valid[g]),
      .req1_ready (req1_ready[g]),
      .req1_data  (req1_data[g]),
      .rsp1_valid (rsp1_valid[g]),
      .rsp1_ready (rsp1_ready[g]),
      .rsp1_data  (rsp1_data[g]),
      .mix_in     (mix_in[g]),
      .fwd_en     (fwd_en[g]),
      .inv_en     (inv_en[g]),
      .fwd_out    (fwd_out[g]),
      .inv_out    (inv_out[g]),
      .busy       (busy[g])
    );

    // Unit output is valid only in the cycle MIX_LAT after the enable; junk otherwise.
    always @(posedge clk) begin
      junk <= rnd128();
      if (!rst_n[g]) begin
        for (int i = 0; i < 4; i++) begin fv[i] <= 1'b0; iv[i] <= 1'b0; end
      end else begin
        fv[0] <= fwd_en[g];
        iv[0] <= inv_en[g];
        fd[0] <= mixcol(mix_in[g], 1'b0);
        id[0] <= mixcol(mix_in[g], 1'b1);
        for (int i = 1; i < 4; i++) begin
          fv[i] <= fv[i-1]; iv[i] <= iv[i-1];
          fd[i] <= fd[i-1]; id[i] <= id[i-1];
        end
      end
    end
    assign fwd_out[g] = (fv[L-1] === 1'b1) ? fd[L-1] : junk;
    assign inv_out[g] = (iv[L-1] === 1'b1) ? id[L-1] : junk;
  end

  // ---------------------------------------------------------------- checking
  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_idle[k] = 1'b1;
    m_t[k]    = 0;
    m_ch[k]   = 1'b0;
    m_last[k] = 1'b1;
    m_mix[k]  = '0;
  endtask

  task automatic chk_reset(input int k);
    check_val($sformatf("rst req0_ready[%0d]", k), 128'(req0_ready[k]), 128'd0);
    check_val($sformatf("rst req1_ready[%0d]", k), 128'(req1_ready[k]), 128'd0);
    check_val($sformatf("rst fwd_en[%0d]", k),     128'(fwd_en[k]),     128'd0);
    check_val($sformatf("rst inv_en[%0d]", k),     128'(inv_en[k]),     128'd0);
    check_val($sformatf("rst busy[%0d]", k),       128'(busy[k]),       128'd0);
    check_val($sformatf("rst mix_in[%0d]", k),     mix_in[k],           128'd0);
    check_val($sformatf("rst rsp0_valid[%0d]", k), 128'(rsp0_valid[k]), 128'd0);
    check_val($sformatf("rst rsp1_valid[%0d]", k), 128'(rsp1_valid[k]), 128'd0);
    check_val($sformatf("rst rsp0_data[%0d]", k),  rsp0_data[k],        128'd0);
    check_val($sformatf("rst rsp1_data[%0d]", k),  rsp1_data[k],        128'd0);
  endtask

  // One clock cycle on instance k: drive, check against the model, advance the model.
  task automatic cyc(input int k, input bit v0, input bit v1,
                     input logic [127:0] d0, input logic [127:0] d1,
                     input bit r0, input bit r1);
    bit eg, er0, er1, resp;
    int L = lat(k);
    req0_valid[k] = v0; req0_data[k] = d0;
    req1_valid[k] = v1; req1_data[k] = d1;
    rsp0_ready[k] = r0; rsp1_ready[k] = r1;
    @(negedge clk);
    eg   = (v0 && v1) ? ~m_last[k] : v1;
    er0  = m_idle[k] && v0 && !eg;
    er1  = m_idle[k] && v1 &&  eg;
    resp = !m_idle[k] && (m_t[k] >= L + 2);
    check_val($sformatf("req0_ready[%0d]", k), 128'(req0_ready[k]), 128'(er0));
    check_val($sformatf("req1_ready[%0d]", k), 128'(req1_ready[k]), 128'(er1));
    check_val($sformatf("busy[%0d]", k),       128'(busy[k]),       128'(!m_idle[k]));
    check_val($sformatf("fwd_en[%0d]", k),     128'(fwd_en[k]),
              128'(!m_idle[k] && m_t[k] == 1 && !m_ch[k]));
    check_val($sformatf("inv_en[%0d]", k),     128'(inv_en[k]),
              128'(!m_idle[k] && m_t[k] == 1 &&  m_ch[k]));
    check_val($sformatf("mix_in[%0d]", k),     mix_in[k], m_mix[k]);
    check_val($sformatf("rsp0_valid[%0d]", k), 128'(rsp0_valid[k]), 128'(resp && !m_ch[k]));
    check_val($sformatf("rsp1_valid[%0d]", k), 128'(rsp1_valid[k]), 128'(resp &&  m_ch[k]));
    check_val($sformatf("rsp0_data[%0d]", k),  rsp0_data[k],
              (resp && !m_ch[k]) ? mixcol(m_mix[k], 1'b0) : 128'd0);
    check_val($sformatf("rsp1_data[%0d]", k),  rsp1_data[k],
              (resp &&  m_ch[k]) ? mixcol(m_mix[k], 1'b1) : 128'd0);
    if (req0_ready[k] && v0) acc_q.push_back(0);
    if (req1_ready[k] && v1) acc_q.push_back(1);
    if (rsp0_valid[k] && r0) obs_rsp0 = rsp0_data[k];
    if (rsp1_valid[k] && r1) obs_rsp1 = rsp1_data[k];
    if (m_idle[k]) begin
      if (v0 || v1) begin
        m_idle[k] = 1'b0; m_ch[k] = eg; m_last[k] = eg;
        m_mix[k]  = eg ? d1 : d0; m_t[k] = 1;
      end
    end else if (resp && (m_ch[k] ? r1 : r0)) begin
      m_idle[k] = 1'b1;
    end else if (!resp) begin
      m_t[k]++;
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_cycles(input int k, input int n);
    for (int i = 0; i < n; i++)
      cyc(k, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rnd128(), rnd128(),
          $urandom_range(0, 4) < 3, $urandom_range(0, 4) < 3);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [127:0] c_pt;
    logic [127:0] c_mc;
    int exp_gnt [4];
    c_pt = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    c_mc = 128'h046681e5e0cb199a48f8d37a2806264c;
    exp_gnt[0] = 0; exp_gnt[1] = 1; exp_gnt[2] = 0; exp_gnt[3] = 1;
    obs_rsp0 = '0;
    obs_rsp1 = '0;

    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      req0_valid[k] = 1'b1; req0_data[k] = c_pt;
      req1_valid[k] = 1'b0; req1_data[k] = '0;
      rsp0_ready[k] = 1'b0; rsp1_ready[k] = 1'b0;
      model_reset(k);
    end
    #3;
    chk_reset(0);
    chk_reset(1);
    repeat (2) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    for (int k = 0; k < 2; k++) req0_valid[k] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Known vector forward, accepted in the very first cycle after reset.
    cyc(0, 1, 0, c_pt, '0, 1, 1);
    repeat (4) cyc(0, 0, 0, '0, '0, 1, 1);
    check_val("fwd vector", obs_rsp0, c_mc);

    // Known vector inverse.
    cyc(0, 0, 1, '0, c_mc, 1, 1);
    repeat (4) cyc(0, 0, 0, '0, '0, 1, 1);
    check_val("inv vector", obs_rsp1, c_pt);

    // Continuous tie: grants must alternate 0,1,0,1.
    acc_q.delete();
    repeat (22) cyc(0, 1, 1, rnd128(), rnd128(), 1, 1);
    repeat (4) cyc(0, 0, 0, '0, '0, 1, 1);
    check_val("tie grant count", 128'(acc_q.size() >= 4), 128'd1);
    for (int i = 0; i < 4; i++)
      if (i < acc_q.size()) check_val($sformatf("tie grant %0d", i), 128'(acc_q[i]), 128'(exp_gnt[i]));

    // Response back-pressure: ready low five RESP cycles with new requests pending.
    cyc(0, 1, 0, rnd128(), '0, 0, 0);
    repeat (2) cyc(0, 0, 0, '0, '0, 0, 0);
    repeat (5) cyc(0, 1, 1, rnd128(), rnd128(), 0, 0);
    cyc(0, 0, 0, '0, '0, 1, 0);
    repeat (2) cyc(0, 0, 0, '0, '0, 1, 1);

    rand_cycles(0, 400);

    // MIX_LAT=3: abort an operation in WAIT with an asynchronous reset pulse.
    rand_cycles(1, 40);
    repeat (8) cyc(1, 0, 0, '0, '0, 1, 1);
    cyc(1, 0, 1, '0, rnd128(), 1, 1);
    repeat (2) cyc(1, 0, 0, '0, '0, 1, 1);
    #2;
    rst_n[1] = 1'b0;
    #1;
    chk_reset(1);
    model_reset(1);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    repeat (10) cyc(1, 0, 0, '0, '0, 1, 1);
    cyc(1, 1, 0, c_pt, '0, 1, 1);
    repeat (6) cyc(1, 0, 0, '0, '0, 1, 1);
    check_val("lat3 fwd vector", obs_rsp0, c_mc);

    rand_cycles(1, 400);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
